// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared width default, ALU op, transfer source and mode encodings
package reg_alu_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} alu_op_e;
    typedef enum logic [1:0] {SRC_A = 2'b00, SRC_B = 2'b01, SRC_C = 2'b10, SRC_ZERO = 2'b11} src_e;
    typedef enum logic {MODE_ALU = 1'b0, MODE_TRANS = 1'b1} mode_e;
endpackage

// File: rtl/reg_alu_trans_if.sv
// reg_alu_trans_if: board buttons/switches in, register and ALU debug values out
interface reg_alu_trans_if import reg_alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic [3:0]       BTN_Y;
    logic [15:0]      SW;
    logic [WIDTH-1:0] debug_A;
    logic [WIDTH-1:0] debug_B;
    logic [WIDTH-1:0] debug_C;
    logic [WIDTH-1:0] debug_res;
    modport master (output BTN_Y, SW, input debug_A, debug_B, debug_C, debug_res);
    modport slave (input BTN_Y, SW, output debug_A, debug_B, debug_C, debug_res);
endinterface

// File: rtl/alu4.sv
// alu4: combinational add/sub/and/or, results modulo 2^WIDTH
module alu4 import reg_alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res
);
    always_comb begin
        res = op == OP_ADD ? a + b :
              op == OP_SUB ? a - b :
              op == OP_AND ? a & b : a | b;
    end
endmodule

// File: rtl/reg_alu_trans_top.sv
// reg_alu_trans_top: A/B/C registers stepped, ALU-latched or transferred by button events.
// TOP_BTN3_CLR_EN: BTN_Y[3] event clears A, B, C with priority over other events.
module reg_alu_trans_top import reg_alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic             clk,
    input logic             rst_n,
    reg_alu_trans_if.slave  bus
);
`ifdef TOP_BTN3_CLR_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    logic [NB-1:0]    btn_cap_q, btn_prev_q, evt;
    logic [WIDTH-1:0] a_q, b_q, c_q, a_d, b_d, c_d, src, res;
    logic             clr, unused_ok;
    mode_e            mode;
    src_e             sel;

    alu4 #(.WIDTH(WIDTH)) u_alu (.a(a_q), .b(b_q), .op(alu_op_e'(bus.SW[3:2])), .res(res));

    // Falling-edge capture catches short pulses that straddle the low phase
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) btn_cap_q <= '0;
        else btn_cap_q <= bus.BTN_Y[NB-1:0];
    end

    assign evt  = btn_cap_q & ~btn_prev_q;
    assign mode = mode_e'(bus.SW[15]);
    assign sel  = src_e'(bus.SW[5:4]);
`ifdef TOP_BTN3_CLR_EN
    assign clr       = evt[3];
    assign unused_ok = ^bus.SW[14:6];
`else
    assign clr       = 1'b0;
    assign unused_ok = ^{bus.SW[14:6], bus.BTN_Y[3]};
`endif

    always_comb begin
        src = sel == SRC_A ? a_q : sel == SRC_B ? b_q : sel == SRC_C ? c_q : '0;
        a_d = clr ? '0 : !evt[0] ? a_q : mode == MODE_TRANS ? src : bus.SW[0] ? a_q - WIDTH'(1) : a_q + WIDTH'(1);
        b_d = clr ? '0 : !evt[1] ? b_q : mode == MODE_TRANS ? src : bus.SW[1] ? b_q - WIDTH'(1) : b_q + WIDTH'(1);
        c_d = clr ? '0 : !evt[2] ? c_q : mode == MODE_TRANS ? src : res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
        end else begin
            btn_prev_q <= btn_cap_q;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
        end
    end

    assign bus.debug_A   = a_q;
    assign bus.debug_B   = b_q;
    assign bus.debug_C   = c_q;
    assign bus.debug_res = res;
endmodule

// File: tb/tb_reg_alu_trans_top.sv
// tb_reg_alu_trans_top: table-driven button/switch vectors with an expected-value scoreboard
module tb_reg_alu_trans_top;
    typedef struct {
        logic [3:0]  btn;
        logic [15:0] sw;
        logic [3:0]  a, b, c, res;
    } vec_t;
    typedef struct {
        logic [3:0] a, b, c, res;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    vec_t vt[$];

    reg_alu_trans_if #(.WIDTH(4)) bus ();
    reg_alu_trans_top #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] swv(input logic mode, input logic [1:0] tsel,
                                        input logic [1:0] aluc, input logic bctl, input logic actl);
        return {mode, 9'b0, tsel, aluc, bctl, actl};
    endfunction

    function automatic vec_t mk(input logic [3:0] btn, input logic [15:0] sw,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] res);
        vec_t v;
        v.btn = btn; v.sw = sw; v.a = a; v.b = b; v.c = c; v.res = res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".A"}, bus.debug_A, e.a);
            chk({tag, ".B"}, bus.debug_B, e.b);
            chk({tag, ".C"}, bus.debug_C, e.c);
            chk({tag, ".res"}, bus.debug_res, e.res);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] res);
        exp_t e;
        e.a = a; e.b = b; e.c = c; e.res = res;
        sb.push_back(e);
    endtask

    // 5 ns pulse straddling a falling edge, then settle two rising edges
    task automatic apply(input vec_t v, input string tag);
        push(v.a, v.b, v.c, v.res);
        @(posedge clk);
        #2;
        bus.SW = v.sw;
        bus.BTN_Y = v.btn;
        #5;
        bus.BTN_Y = 4'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        pop_cmp(tag);
    endtask

    initial begin
        bus.BTN_Y = 4'b0;
        bus.SW = 16'b0;
        #1 rst_n = 1'b0;
        #10;
        push(0, 0, 0, 0);
        pop_cmp("reset");
        #2 rst_n = 1'b1;

        vt.push_back(mk(4'b0001, swv(0, 0, 2'b00, 0, 0), 1, 0, 0, 1));
        vt.push_back(mk(4'b0010, swv(0, 0, 2'b00, 0, 0), 1, 1, 0, 2));
        vt.push_back(mk(4'b0010, swv(0, 0, 2'b00, 0, 0), 1, 2, 0, 3));
        vt.push_back(mk(4'b0010, swv(0, 0, 2'b00, 0, 0), 1, 3, 0, 4));
        vt.push_back(mk(4'b0010, swv(0, 0, 2'b00, 1, 0), 1, 2, 0, 3));
        vt.push_back(mk(4'b0100, swv(0, 0, 2'b00, 0, 0), 1, 2, 3, 3));
        vt.push_back(mk(4'b0100, swv(0, 0, 2'b01, 0, 0), 1, 2, 15, 15));
        vt.push_back(mk(4'b0100, swv(0, 0, 2'b10, 0, 0), 1, 2, 0, 0));
        vt.push_back(mk(4'b0100, swv(0, 0, 2'b11, 0, 0), 1, 2, 3, 3));
        vt.push_back(mk(4'b0001, swv(1, 2'b10, 2'b00, 0, 0), 3, 2, 3, 5));
        vt.push_back(mk(4'b0010, swv(1, 2'b11, 2'b00, 0, 0), 3, 0, 3, 3));
        vt.push_back(mk(4'b0010, swv(1, 2'b10, 2'b00, 0, 0), 3, 3, 3, 6));
        vt.push_back(mk(4'b0100, swv(1, 2'b11, 2'b00, 0, 0), 3, 3, 0, 6));
        vt.push_back(mk(4'b0001, swv(0, 0, 2'b00, 0, 1), 2, 3, 0, 5));
        vt.push_back(mk(4'b0001, swv(0, 0, 2'b00, 0, 1), 1, 3, 0, 4));
        vt.push_back(mk(4'b0001, swv(0, 0, 2'b00, 0, 1), 0, 3, 0, 3));
        vt.push_back(mk(4'b0001, swv(0, 0, 2'b00, 0, 1), 15, 3, 0, 2));
        vt.push_back(mk(4'b0100, swv(1, 2'b10, 2'b00, 0, 0), 15, 3, 0, 2));
        vt.push_back(mk(4'b0010, swv(1, 2'b01, 2'b00, 0, 0), 15, 3, 0, 2));
        vt.push_back(mk(4'b0001, swv(1, 2'b00, 2'b00, 0, 0), 15, 3, 0, 2));
        vt.push_back(mk(4'b0100, swv(1, 2'b01, 2'b00, 0, 0), 15, 3, 3, 2));
        vt.push_back(mk(4'b0100, swv(1, 2'b00, 2'b00, 0, 0), 15, 3, 15, 2));
        vt.push_back(mk(4'b0010, swv(1, 2'b00, 2'b00, 0, 0), 15, 15, 15, 14));
        vt.push_back(mk(4'b0101, swv(0, 0, 2'b00, 0, 0), 0, 15, 14, 15));
        vt.push_back(mk(4'b0000, swv(1, 2'b11, 2'b00, 0, 0), 0, 15, 14, 15));
`ifdef TOP_BTN3_CLR_EN
        vt.push_back(mk(4'b1000, swv(0, 0, 2'b00, 0, 0), 0, 0, 0, 0));
        vt.push_back(mk(4'b1001, swv(0, 0, 2'b00, 0, 0), 0, 0, 0, 0));
`else
        vt.push_back(mk(4'b1000, swv(0, 0, 2'b00, 0, 0), 0, 15, 14, 15));
        vt.push_back(mk(4'b1001, swv(0, 0, 2'b00, 0, 0), 1, 15, 14, 0));
`endif
        foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

        // Decrement wraps 0 -> 15 right after reset
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        apply(mk(4'b0001, swv(0, 0, 2'b00, 0, 1), 15, 0, 0, 15), "wrap");

        // Held button: one event across five clocks
        push(0, 0, 0, 0);
        @(posedge clk);
        #2;
        bus.SW = swv(0, 0, 2'b00, 0, 0);
        bus.BTN_Y = 4'b0001;
        repeat (5) @(posedge clk);
        #2 bus.BTN_Y = 4'b0;
        repeat (2) @(posedge clk);
        #1 pop_cmp("held");

        apply(mk(4'b0110, swv(0, 0, 2'b00, 0, 0), 0, 1, 0, 1), "pre_rst");

        // Async reset clears mid-cycle, before any rising edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        push(0, 0, 0, 0);
        pop_cmp("async_rst");
        #2 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
